// File: rtl/ring_edge_counter.sv
// Ring-oscillator edge counter: runs the adder's ring loop, lets it settle, then
// counts synchronised rising edges of ring_in over a programmed wb_clk_i window.
module ring_edge_counter #(
    parameter int CNT_W       = 32,
    parameter int WIN_W       = 32,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] window_cycles,
    input  logic             ring_in,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIN_W-1:0]       left_q, left_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   rise;

    // Synchroniser and edge history run in every state so the first COUNT
    // cycle already sees a valid previous sample.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ring_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        settle_d   = settle_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    left_d     = window_cycles;
                    settle_d   = SETTLE_LAST;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (settle_q == '0) begin
                    state_d = (left_q == '0) ? DONE : COUNT;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            COUNT: begin
                if (rise) begin
                    // Saturate instead of wrapping; overflow records the lost edge.
                    if (&count_q) overflow_d = 1'b1;
                    else          count_d    = count_q + 1'b1;
                end
                left_d = left_q - 1'b1;
                if (left_q == WIN_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            left_q     <= '0;
            settle_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            left_q     <= left_d;
            settle_q   <= settle_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign ring_en  = (state_q == ARM) || (state_q == COUNT);
    assign busy     = ring_en;
    assign done     = (state_q == DONE);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_edge_counter.sv
// Bench for ring_edge_counter: a window-level reference model over the sampled
// ring_in history checks two instances (32-bit and 4-bit counters) every cycle.
module tb_ring_edge_counter;

    localparam int SETTLE = 4;
    localparam int S      = 2;

    logic        clk = 1'b0;
    logic        reset, start, ring_in;
    logic [31:0] window;
    logic        ring_en, busy, done, overflow;
    logic [31:0] count;
    logic        ring_en4, busy4, done4, overflow4;
    logic [3:0]  count4;

    int vectors = 0;
    int miscompares = 0;

    ring_edge_counter #(.CNT_W(32), .WIN_W(32), .SETTLE(SETTLE), .SYNC_STAGES(S)) u_dut (
        .wb_clk_i(clk), .reset(reset), .start(start), .window_cycles(window),
        .ring_in(ring_in), .ring_en(ring_en), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
    );

    ring_edge_counter #(.CNT_W(4), .WIN_W(32), .SETTLE(SETTLE), .SYNC_STAGES(S)) u_dut4 (
        .wb_clk_i(clk), .reset(reset), .start(start), .window_cycles(window),
        .ring_in(ring_in), .ring_en(ring_en4), .busy(busy4), .done(done4),
        .count(count4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ring stimulus: fixed period (50%-ish duty) or random bits, changed on negedge.
    int ring_period = 2;
    int ph = 0;
    initial ring_in = 1'b0;
    always @(negedge clk) begin
        ph++;
        if (ring_period == 0) ring_in = 1'($urandom_range(0, 1));
        else                  ring_in = ((ph % ring_period) < (ring_period / 2));
    end

    // Reference model: a run accepted at edge t counts rising transitions of the
    // synchronised sample stream over cycles following edges t+SETTLE .. t+SETTLE+W-1.
    bit     hist[$];
    int     e, x, t_acc, w_lat;
    bit     m_active = 0, m_done = 0, was_done, m_valid = 0;
    longint n = 0;

    always @(posedge clk) begin
        hist.push_back(ring_in);
        e = hist.size() - 1;
        if (reset) begin
            m_active = 0;
            m_done   = 0;
            n        = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            if (m_active) begin
                x = e - 1;
                if (x >= t_acc + SETTLE && x < t_acc + SETTLE + w_lat &&
                    hist[x-S+1] && !hist[x-S])
                    n++;
                if (e == t_acc + SETTLE + w_lat) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (!was_done && start) begin
                m_active = 1;
                t_acc    = e;
                w_lat    = int'(window);
                n        = 0;
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ring_en",   ring_en,   m_active);
            chk("busy",      busy,      m_active);
            chk("done",      done,      m_done);
            chk("count",     count,     (n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : n);
            chk("overflow",  overflow,  n > 64'hFFFF_FFFF);
            chk("busy4",     busy4,     m_active);
            chk("ring_en4",  ring_en4,  m_active);
            chk("done4",     done4,     m_done);
            chk("count4",    count4,    (n > 15) ? 15 : n);
            chk("overflow4", overflow4, n > 15);
        end
    end

    // Start a run from IDLE; k_done is the cycle offset of done (1 = cycle after acceptance edge).
    task automatic run_meas(input int w, output int k_done, output int busy_n);
        window = w;
        start  = 1'b1;
        k_done = -1;
        busy_n = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (busy) busy_n++;
            if (done) begin
                k_done = k;
                break;
            end
            @(negedge clk);
        end
        if (k_done < 0) chk("run_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    int k, b, kd, nd, d1, d2;

    initial begin
        reset = 1'b1; start = 1'b0; window = '0;
        repeat (3) @(negedge clk);
        chk("rst_ring_en", ring_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0; ring_period = 4;
        @(negedge clk);

        // Nominal window
        run_meas(100, k, b);
        chk("nom_done_cycle", k, 105);
        chk("nom_count", count, 25);
        chk("nom_ring_en_cycles", b, 104);
        chk("nom_overflow", overflow, 0);
        @(negedge clk);

        // Zero window
        run_meas(0, k, b);
        chk("zero_done_cycle", k, 5);
        chk("zero_count", count, 0);
        chk("zero_overflow", overflow, 0);
        @(negedge clk);

        // Saturation of the 4-bit instance
        ring_period = 2;
        @(negedge clk);
        run_meas(40, k, b);
        chk("sat_count4", count4, 15);
        chk("sat_overflow4", overflow4, 1);
        chk("sat_count32", count, 20);
        chk("sat_overflow32", overflow, 0);
        repeat (10) @(negedge clk);
        chk("sat_hold_count4", count4, 15);
        chk("sat_hold_overflow4", overflow4, 1);
        window = 10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sat_clr_overflow4", overflow4, 0);
        chk("sat_clr_count4", count4, 0);
        repeat (20) @(negedge clk);

        // Start pulses and window change while busy are ignored
        ring_period = 4;
        window = 100; start = 1'b1; kd = -1; nd = 0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 130; j++) begin
            if (j >= 10 && j <= 12) start = 1'b1;
            if (j == 13) start = 1'b0;
            if (j == 20) window = 7;
            if (done) begin
                nd++;
                if (kd < 0) kd = j;
                if (nd == 1) chk("poke_count", count, 25);
            end
            @(negedge clk);
        end
        chk("poke_done_cycle", kd, 105);
        chk("poke_done_pulses", nd, 1);

        // Reset in the middle of COUNT
        window = 100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ring_en", ring_en, 0);
        chk("midrst_count", count, 0);
        chk("midrst_done", done, 0);
        nd = 0;
        repeat (120) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst_no_done", nd, 0);
        run_meas(100, k, b);
        chk("midrst_rerun_count", count, 25);
        chk("midrst_rerun_cycle", k, 105);
        @(negedge clk);

        // Start held high: back-to-back runs with one idle cycle between
        window = 3; start = 1'b1; d1 = -1; d2 = -1;
        @(negedge clk);
        for (int j = 1; j <= 40; j++) begin
            if (done) begin
                if (d1 < 0) d1 = j;
                else if (d2 < 0) d2 = j;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_first_done", d1, 8);
        chk("b2b_second_done", d2, 17);
        repeat (20) @(negedge clk);

        // Randomised traffic, checked every cycle by the model
        begin
            bit hold = 0;
            for (int j = 0; j < 3000; j++) begin
                if ($urandom_range(0, 299) == 0) begin
                    case ($urandom_range(0, 5))
                        0: ring_period = 0;
                        1: ring_period = 2;
                        2: ring_period = 3;
                        3: ring_period = 4;
                        4: ring_period = 5;
                        default: ring_period = 7;
                    endcase
                end
                if ($urandom_range(0, 199) == 0) hold = ~hold;
                start  = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
                window = $urandom_range(0, 30);
                reset  = ($urandom_range(0, 249) == 0);
                @(negedge clk);
            end
        end
        reset = 1'b0; start = 1'b0;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
